// File: rtl/combo_lock_pkg.sv
// Shared types and sizing helpers for the combination lock controller.
package combo_lock_pkg;

  typedef enum logic [1:0] {ENTRY, OPEN, PROG, LOCKOUT} state_t;

  // Timer width from the largest period. The +1 keeps an exact power of two representable.
  function automatic int tmr_width(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return $clog2(m + 1);
  endfunction

  localparam int TMR_W = tmr_width(500, 1000, 200);

endpackage

// File: rtl/combo_lock_cycle_timer.sv
// Loadable down-counter. done pulses in the last counted cycle, so a load of N
// gives N cycles (including the cycle after the load) up to and including the done cycle.
module cycle_timer #(
  parameter int W = 10
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         clr,
  output logic         done
);

  logic [W-1:0] cnt;

  // Count register: clear wins over load, otherwise count down to zero and stop.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST)                cnt <= '0;
    else if (clr)            cnt <= '0;
    else if (load)           cnt <= load_val;
    else if (cnt != '0)      cnt <= cnt - W'(1);
  end

  assign done = (cnt == W'(1));

endmodule

// File: rtl/combo_lock_ctrl.sv
// Attempt-based combination lock controller: collects CODE_LEN-bit attempts,
// times the unlock window, counts failures and enforces lockout.
// Optional macro COMBO_ENTRY_TIMEOUT_EN discards stale partial entries.
module combo_lock_ctrl
  import combo_lock_pkg::*;
#(
  parameter int                  CODE_LEN       = 5,
  parameter logic [CODE_LEN-1:0] DEFAULT_CODE   = 5'b01011,
  parameter int                  MAX_FAILS      = 3,
  parameter int                  UNLOCK_CYCLES  = 500,
  parameter int                  LOCKOUT_CYCLES = 1000,
  parameter int                  ENTRY_TIMEOUT  = 200
) (
  input  logic                               CLK,
  input  logic                               RST,
  input  logic                               btn_valid,
  input  logic                               btn_bit,
  input  logic                               prog_req,
  input  logic                               relock,
  output logic                               unlock,
  output logic                               locked_out,
  output logic                               prog_mode,
  output logic [$clog2(MAX_FAILS+1)-1:0]     fail_cnt,
  output logic [$clog2(CODE_LEN+1)-1:0]      digit_cnt
);

  localparam int FW = $clog2(MAX_FAILS + 1);
  localparam int DW = $clog2(CODE_LEN + 1);
  localparam int TW = tmr_width(UNLOCK_CYCLES, LOCKOUT_CYCLES, ENTRY_TIMEOUT);

  state_t                state, nxt;
  logic [CODE_LEN-1:0]   shreg, sh_n, code, code_n, collected;
  logic [DW-1:0]         dc_n;
  logic [FW-1:0]         fc_n;
  logic                  last;
  logic                  t_load, t_clr, t_done;
  logic [TW-1:0]         t_val;
  logic                  e_load, e_clr, ent_exp;

  assign collected = {shreg[CODE_LEN-2:0], btn_bit};
  assign last      = (digit_cnt == DW'(CODE_LEN - 1));

  // Unlock and lockout never overlap, so one timer serves both.
  cycle_timer #(.W(TW)) u_tmr (
    .CLK(CLK), .RST(RST), .load(t_load), .load_val(t_val), .clr(t_clr), .done(t_done)
  );

`ifdef COMBO_ENTRY_TIMEOUT_EN
  logic e_done;
  // Reloaded on every accepted non-final bit; expiry only counts if this cycle is idle.
  cycle_timer #(.W(TW)) u_ent_tmr (
    .CLK(CLK), .RST(RST), .load(e_load), .load_val(TW'(ENTRY_TIMEOUT)), .clr(e_clr), .done(e_done)
  );
  assign ent_exp = e_done && !btn_valid && (digit_cnt != '0) && (state == ENTRY || state == PROG);
`else
  logic unused_ent;
  assign unused_ent = ^{e_load, e_clr};
  assign ent_exp    = 1'b0;
`endif

  // Next-state and datapath updates; priority relock > prog_req > timer expiry > btn_valid.
  always_comb begin
    nxt    = state;
    sh_n   = shreg;
    dc_n   = digit_cnt;
    fc_n   = fail_cnt;
    code_n = code;
    t_load = 1'b0;
    t_val  = '0;
    t_clr  = 1'b0;
    e_load = 1'b0;
    e_clr  = 1'b0;
    case (state)
      ENTRY: begin
        if (ent_exp) begin
          sh_n = '0;
          dc_n = '0;
        end else if (btn_valid) begin
          if (last) begin
            sh_n  = '0;
            dc_n  = '0;
            e_clr = 1'b1;
            if (collected == code) begin
              nxt    = OPEN;
              fc_n   = '0;
              t_load = 1'b1;
              t_val  = TW'(UNLOCK_CYCLES);
            end else begin
              if (fail_cnt != FW'(MAX_FAILS)) fc_n = fail_cnt + FW'(1);
              if (fail_cnt + FW'(1) == FW'(MAX_FAILS)) begin
                nxt    = LOCKOUT;
                t_load = 1'b1;
                t_val  = TW'(LOCKOUT_CYCLES);
              end
            end
          end else begin
            sh_n   = collected;
            dc_n   = digit_cnt + DW'(1);
            e_load = 1'b1;
          end
        end
      end
      OPEN: begin
        if (relock) begin
          nxt   = ENTRY;
          t_clr = 1'b1;
        end else if (prog_req) begin
          nxt   = PROG;
          t_clr = 1'b1;
          sh_n  = '0;
          dc_n  = '0;
        end else if (t_done) begin
          nxt = ENTRY;
        end
      end
      PROG: begin
        if (relock || ent_exp) begin
          nxt   = ENTRY;
          sh_n  = '0;
          dc_n  = '0;
          e_clr = 1'b1;
        end else if (btn_valid) begin
          if (last) begin
            code_n = collected;
            nxt    = ENTRY;
            sh_n   = '0;
            dc_n   = '0;
            e_clr  = 1'b1;
          end else begin
            sh_n   = collected;
            dc_n   = digit_cnt + DW'(1);
            e_load = 1'b1;
          end
        end
      end
      LOCKOUT: begin
        if (t_done) begin
          nxt  = ENTRY;
          fc_n = '0;
          dc_n = '0;
          sh_n = '0;
        end
      end
      default: nxt = ENTRY;
    endcase
  end

  // State, datapath and registered status outputs decoded from the next state.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state      <= ENTRY;
      shreg      <= '0;
      code       <= DEFAULT_CODE;
      digit_cnt  <= '0;
      fail_cnt   <= '0;
      unlock     <= 1'b0;
      locked_out <= 1'b0;
      prog_mode  <= 1'b0;
    end else begin
      state      <= nxt;
      shreg      <= sh_n;
      code       <= code_n;
      digit_cnt  <= dc_n;
      fail_cnt   <= fc_n;
      unlock     <= (nxt == OPEN);
      locked_out <= (nxt == LOCKOUT);
      prog_mode  <= (nxt == PROG);
    end
  end

endmodule

// File: tb/tb_combo_lock_ctrl.sv
// Self-checking bench for combo_lock_ctrl: table of stimulus rows with
// expected outputs, scoreboard queue, hand sequences for reset and timeout.
module tb_combo_lock_ctrl;

  logic       CLK = 1'b0;
  logic       RST = 1'b0;
  logic       btn_valid = 1'b0, btn_bit = 1'b0, prog_req = 1'b0, relock = 1'b0;
  logic       unlock, locked_out, prog_mode;
  logic [1:0] fail_cnt;
  logic [2:0] digit_cnt;

  combo_lock_ctrl dut (
    .CLK(CLK), .RST(RST), .btn_valid(btn_valid), .btn_bit(btn_bit),
    .prog_req(prog_req), .relock(relock), .unlock(unlock),
    .locked_out(locked_out), .prog_mode(prog_mode),
    .fail_cnt(fail_cnt), .digit_cnt(digit_cnt)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    int   reps;
    logic v, b, p, r;
    logic eu, elo, epm;
    int   efc, edc;
  } vec_t;

  typedef struct {
    logic eu, elo, epm;
    int   efc, edc, row;
  } exp_t;

  vec_t tbl[$];
  exp_t exp_q[$];
  int   n_chk = 0;
  int   n_fail = 0;
  int   rowno = 0;

  task automatic chk(input string nm, input int row, input int act, input int want);
    n_chk++;
    if (act != want) begin
      n_fail++;
      $display("FAIL %s row %0d: got %0d want %0d", nm, row, act, want);
    end
  endtask

  task automatic add(input int reps, input logic v, b, p, r,
                     input logic eu, elo, epm, input int efc, edc);
    vec_t t;
    t.reps = reps; t.v = v; t.b = b; t.p = p; t.r = r;
    t.eu = eu; t.elo = elo; t.epm = epm; t.efc = efc; t.edc = edc;
    tbl.push_back(t);
  endtask

  // Full 5-bit entry: digit_cnt climbs 1..4 with outputs held, final row as given.
  task automatic add_code(input logic [4:0] c, input int fc0, input logic pm0,
                          input logic eu, elo, epm, input int efc);
    for (int i = 0; i < 4; i++) add(1, 1'b1, c[4-i], 1'b0, 1'b0, 1'b0, 1'b0, pm0, fc0, i + 1);
    add(1, 1'b1, c[0], 1'b0, 1'b0, eu, elo, epm, efc, 0);
  endtask

  // Five presses that must be ignored (outputs constant, digit_cnt stays 0).
  task automatic add_ign(input logic [4:0] c, input logic eu, elo, epm, input int efc);
    for (int i = 0; i < 5; i++) add(1, 1'b1, c[4-i], 1'b0, 1'b0, eu, elo, epm, efc, 0);
  endtask

  task automatic step(input vec_t t, input int row);
    exp_t e;
    btn_valid = t.v; btn_bit = t.b; prog_req = t.p; relock = t.r;
    e.eu = t.eu; e.elo = t.elo; e.epm = t.epm; e.efc = t.efc; e.edc = t.edc; e.row = row;
    exp_q.push_back(e);
    @(posedge CLK);
    #1;
    e = exp_q.pop_front();
    chk("unlock",     e.row, int'(unlock),     int'(e.eu));
    chk("locked_out", e.row, int'(locked_out), int'(e.elo));
    chk("prog_mode",  e.row, int'(prog_mode),  int'(e.epm));
    chk("fail_cnt",   e.row, int'(fail_cnt),   e.efc);
    chk("digit_cnt",  e.row, int'(digit_cnt),  e.edc);
    btn_valid = 1'b0; btn_bit = 1'b0; prog_req = 1'b0; relock = 1'b0;
  endtask

  task automatic run_table();
    foreach (tbl[i]) begin
      for (int k = 0; k < tbl[i].reps; k++) step(tbl[i], rowno);
      rowno++;
    end
    tbl.delete();
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_unlock"},     rowno, int'(unlock),     0);
    chk({tag, "_locked_out"}, rowno, int'(locked_out), 0);
    chk({tag, "_prog_mode"},  rowno, int'(prog_mode),  0);
    chk({tag, "_fail_cnt"},   rowno, int'(fail_cnt),   0);
    chk({tag, "_digit_cnt"},  rowno, int'(digit_cnt),  0);
  endtask

  initial begin
    #12;
    chk_zero("reset");
    RST = 1'b1;
    @(posedge CLK);
    #1;

    // Correct default code, 500-cycle unlock window, then closed.
    add_code(5'b01011, 0, 1'b0, 1'b1, 1'b0, 1'b0, 0);
    add(499, 0, 0, 0, 0, 1'b1, 1'b0, 1'b0, 0, 0);
    add(1,   0, 0, 0, 0, 1'b0, 1'b0, 1'b0, 0, 0);
    // Three failures -> lockout of 1000 cycles; presses during lockout ignored.
    add_code(5'b11111, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1);
    add_code(5'b11111, 1, 1'b0, 1'b0, 1'b0, 1'b0, 2);
    add_code(5'b11111, 2, 1'b0, 1'b0, 1'b1, 1'b0, 3);
    add_ign(5'b01011, 1'b0, 1'b1, 1'b0, 3);
    add(994, 0, 0, 0, 0, 1'b0, 1'b1, 1'b0, 3, 0);
    add(1,   0, 0, 0, 0, 1'b0, 1'b0, 1'b0, 0, 0);
    add_code(5'b01011, 0, 1'b0, 1'b1, 1'b0, 1'b0, 0);
    // Open: presses ignored, then reprogram to 11100.
    add_ign(5'b11111, 1'b1, 1'b0, 1'b0, 0);
    add(1, 0, 0, 1, 0, 1'b0, 1'b0, 1'b1, 0, 0);
    add_code(5'b11100, 0, 1'b1, 1'b0, 1'b0, 1'b0, 0);
    add_code(5'b01011, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1);
    add_code(5'b11100, 1, 1'b0, 1'b1, 1'b0, 1'b0, 0);
    // Relock at cycle 10, then relock+prog_req together must not enter PROG.
    add(9, 0, 0, 0, 0, 1'b1, 1'b0, 1'b0, 0, 0);
    add(1, 0, 0, 0, 1, 1'b0, 1'b0, 1'b0, 0, 0);
    add_code(5'b11100, 0, 1'b0, 1'b1, 1'b0, 1'b0, 0);
    add(1, 0, 0, 1, 1, 1'b0, 1'b0, 1'b0, 0, 0);
    add(2, 0, 0, 0, 0, 1'b0, 1'b0, 1'b0, 0, 0);
    // Partial attempt before the asynchronous reset.
    add(1, 1, 0, 0, 0, 1'b0, 1'b0, 1'b0, 0, 1);
    add(1, 1, 1, 0, 0, 1'b0, 1'b0, 1'b0, 0, 2);
    add(1, 1, 0, 0, 0, 1'b0, 1'b0, 1'b0, 0, 3);
    run_table();

    // Mid-attempt reset: outputs clear without a clock edge.
    RST = 1'b0;
    #2;
    chk_zero("midreset");
    @(negedge CLK);
    RST = 1'b1;
    @(posedge CLK);
    #1;

    // Programmed code is gone; default restored and no stale digits.
    add_code(5'b11100, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1);
    add_code(5'b01011, 1, 1'b0, 1'b1, 1'b0, 1'b0, 0);
    add(1, 0, 0, 0, 1, 1'b0, 1'b0, 1'b0, 0, 0);
`ifdef COMBO_ENTRY_TIMEOUT_EN
    // Stale partial discarded after 200 idle cycles, fail_cnt kept.
    add_code(5'b11111, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1);
    add(1, 1, 0, 0, 0, 1'b0, 1'b0, 1'b0, 1, 1);
    add(1, 1, 1, 0, 0, 1'b0, 1'b0, 1'b0, 1, 2);
    add(199, 0, 0, 0, 0, 1'b0, 1'b0, 1'b0, 1, 2);
    add(1,   0, 0, 0, 0, 1'b0, 1'b0, 1'b0, 1, 0);
    add_code(5'b01011, 1, 1'b0, 1'b1, 1'b0, 1'b0, 0);
`endif
    run_table();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
